i2c_gyro_target: RTL

- I2C target (responder) that emulates the MPU6050 register subset our flight-controller driver uses: pointer write, register write, and auto-incrementing burst reads.
- Pairs with the on-chip I2C master in simulation and loopback builds, so the gyro path can be exercised without a physical sensor.
- Gyro samples come in from a testbench or stimulus block. The interrupt output mimics the sensor's data-ready INT pin.

---
 rtl/i2c_gyro_target.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_gyro_target.sv
// rtl/i2c_gyro_target.sv - MPU6050-subset I2C target with shadowed gyro burst reads and data-ready interrupt
// Optional I2C_TGT_GLITCH_FILTER_EN: accept SCL/SDA levels only after 3 stable samples.
module i2c_gyro_target #(
    parameter logic [6:0] SLAVE_ADDR       = 7'h68,
    parameter logic [7:0] WHO_AM_I_VAL     = 8'h68,
    parameter int         INT_PULSE_CYCLES = 2500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scl_i,
    input  logic               sda_i,
    output logic               sda_o,
    input  logic signed [15:0] gyro_x,
    input  logic signed [15:0] gyro_y,
    input  logic signed [15:0] gyro_z,
    input  logic               sample_valid,
    output logic               int_o,
    output logic [7:0]         gyro_config,
    output logic [7:0]         int_pin_cfg,
    output logic [7:0]         int_enable,
    output logic [7:0]         pwr_mgmt_1,
    output logic               busy
);
    localparam int PW = $clog2(INT_PULSE_CYCLES + 1);

    localparam logic [7:0] A_GYRO_CONFIG = 8'd27;
    localparam logic [7:0] A_INT_PIN_CFG = 8'd55;
    localparam logic [7:0] A_INT_ENABLE  = 8'd56;
    localparam logic [7:0] A_INT_STATUS  = 8'd58;
    localparam logic [7:0] A_PWR_MGMT_1  = 8'd107;
    localparam logic [7:0] A_WHO_AM_I    = 8'd117;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RACK, ST_IGNORE
    } state_t;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_lvl, sda_lvl;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_rise, scl_fall, start_c, stop_c;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       sda_q, sda_d;
    logic       mack_q, mack_d;

    logic       reg_wr, shadow_ld, rd_ack_clr, rd58_clr;
    logic [7:0] rd_byte;
    logic [2:0] bit_idx;

    logic [7:0]    gyro_config_q, int_pin_cfg_q, int_enable_q, pwr_mgmt_1_q;
    logic          int_status_q;
    logic [47:0]   live_q, shadow_q;
    logic [PW-1:0] pulse_q;
    logic          int_set, int_clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_filt_q, sda_filt_q;

    // A new level is taken once the current sample and the two before it agree.
    assign scl_lvl = (scl_sync_q[1] == scl_hist_q[0] && scl_sync_q[1] == scl_hist_q[1])
                     ? scl_sync_q[1] : scl_filt_q;
    assign sda_lvl = (sda_sync_q[1] == sda_hist_q[0] && sda_sync_q[1] == sda_hist_q[1])
                     ? sda_sync_q[1] : sda_filt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_filt_q <= scl_lvl;
            sda_filt_q <= sda_lvl;
        end
    end
`else
    assign scl_lvl = scl_sync_q[1];
    assign sda_lvl = sda_sync_q[1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_lvl;
            sda_prev_q <= sda_lvl;
        end
    end

    assign scl_rise = scl_lvl & ~scl_prev_q;
    assign scl_fall = ~scl_lvl & scl_prev_q;
    assign start_c  = scl_lvl & scl_prev_q & ~sda_lvl & sda_prev_q;
    assign stop_c   = scl_lvl & scl_prev_q & sda_lvl & ~sda_prev_q;
    assign bit_idx  = ~cnt_q[2:0];

    always_comb begin
        rd_byte = 8'h00;
        case (ptr_q)
            A_GYRO_CONFIG: rd_byte = gyro_config_q;
            A_INT_PIN_CFG: rd_byte = int_pin_cfg_q;
            A_INT_ENABLE:  rd_byte = int_enable_q;
            A_INT_STATUS:  rd_byte = {7'd0, int_status_q};
            A_PWR_MGMT_1:  rd_byte = pwr_mgmt_1_q;
            A_WHO_AM_I:    rd_byte = WHO_AM_I_VAL;
            8'd67:         rd_byte = shadow_q[47:40];
            8'd68:         rd_byte = shadow_q[39:32];
            8'd69:         rd_byte = shadow_q[31:24];
            8'd70:         rd_byte = shadow_q[23:16];
            8'd71:         rd_byte = shadow_q[15:8];
            8'd72:         rd_byte = shadow_q[7:0];
            default:       rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            ptr_q   <= '0;
            rw_q    <= 1'b0;
            sda_q   <= 1'b1;
            mack_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            ptr_q   <= ptr_d;
            rw_q    <= rw_d;
            sda_q   <= sda_d;
            mack_q  <= mack_d;
        end
    end

    // sda_d only moves on an SCL fall, so SDA never changes while SCL is high.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        sda_d      = sda_q;
        mack_d     = mack_q;
        reg_wr     = 1'b0;
        shadow_ld  = 1'b0;
        rd_ack_clr = 1'b0;
        rd58_clr   = 1'b0;
        if (start_c) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
            sda_d   = 1'b1;
        end else if (stop_c) begin
            state_d = ST_IDLE;
            sda_d   = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR, ST_REG, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_lvl};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d = '0;
                        if (state_q == ST_ADDR) begin
                            if (shift_q[7:1] == SLAVE_ADDR) begin
                                state_d   = ST_ADDR_ACK;
                                sda_d     = 1'b0;
                                rw_d      = shift_q[0];
                                shadow_ld = shift_q[0];
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end else if (state_q == ST_REG) begin
                            ptr_d   = shift_q;
                            state_d = ST_REG_ACK;
                            sda_d   = 1'b0;
                        end else begin
                            reg_wr  = 1'b1;
                            ptr_d   = ptr_q + 8'd1;
                            state_d = ST_WDATA_ACK;
                            sda_d   = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            state_d = ST_RDATA;
                            sda_d   = rd_byte[7];
                        end else begin
                            state_d = ST_REG;
                            sda_d   = 1'b1;
                        end
                    end
                end
                ST_REG_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d = ST_WDATA;
                        sda_d   = 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            cnt_d    = '0;
                            sda_d    = 1'b1;
                            state_d  = ST_RACK;
                            ptr_d    = ptr_q + 8'd1;
                            rd58_clr = (ptr_q == A_INT_STATUS);
                        end else begin
                            sda_d = rd_byte[bit_idx];
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        mack_d     = sda_lvl;
                        rd_ack_clr = ~sda_lvl;
                    end else if (scl_fall) begin
                        if (!mack_q) begin
                            state_d = ST_RDATA;
                            sda_d   = rd_byte[7];
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign int_set = sample_valid & int_enable_q[0];
    assign int_clr = int_pin_cfg_q[4] ? rd_ack_clr : rd58_clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gyro_config_q <= 8'h00;
            int_pin_cfg_q <= 8'h00;
            int_enable_q  <= 8'h00;
            pwr_mgmt_1_q  <= 8'h40;
            int_status_q  <= 1'b0;
            live_q        <= '0;
            shadow_q      <= '0;
            pulse_q       <= '0;
        end else begin
            if (reg_wr) begin
                case (ptr_q)
                    A_GYRO_CONFIG: gyro_config_q <= shift_q;
                    A_INT_PIN_CFG: int_pin_cfg_q <= shift_q;
                    A_INT_ENABLE:  int_enable_q  <= shift_q;
                    A_PWR_MGMT_1:  pwr_mgmt_1_q  <= shift_q;
                    default: ;
                endcase
            end
            if (sample_valid) begin
                live_q <= {gyro_x, gyro_y, gyro_z};
            end
            // A burst reads the snapshot taken at its read address, never the live bank.
            if (shadow_ld) begin
                shadow_q <= live_q;
            end
            int_status_q <= int_set | (int_status_q & ~int_clr);
            if (int_set) begin
                pulse_q <= PW'(INT_PULSE_CYCLES);
            end else if (pulse_q != '0) begin
                pulse_q <= pulse_q - PW'(1);
            end
        end
    end

    assign sda_o       = sda_q;
    assign busy        = (state_q != ST_IDLE);
    assign int_o       = int_pin_cfg_q[5] ? int_status_q : (pulse_q != '0);
    assign gyro_config = gyro_config_q;
    assign int_pin_cfg = int_pin_cfg_q;
    assign int_enable  = int_enable_q;
    assign pwr_mgmt_1  = pwr_mgmt_1_q;
endmodule
